// File: rtl/i2s_sample_player.sv
// I2S transmitter that streams a PCM clip from a synchronous sample memory.
// Software sets the clip bounds, loop, mono/stereo and attenuation over Avalon-MM.
module i2s_sample_player #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned SLOT_W   = 24,
    parameter int unsigned ADDR_W   = 15
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                sclk,
    input  logic                lrclk,
    input  logic                AVL_READ,
    input  logic                AVL_WRITE,
    input  logic                AVL_CS,
    input  logic [1:0]          AVL_ADDR,
    input  logic [31:0]         AVL_WRITEDATA,
    output logic [31:0]         AVL_READDATA,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [SAMPLE_W-1:0] mem_q,
    output logic                data_out,
    output logic                irq
);

    localparam int unsigned CntW = $clog2(SLOT_W);

    typedef enum logic [1:0] {StIdle, StArm, StPlay, StDrain} state_e;

    state_e              state_q, state_d;
    logic [2:0]          sclk_sync_q, lr_sync_q;
    logic [6:0]          ctrl_q, ctrl_d;
    logic [ADDR_W-1:0]   start_addr_q, start_addr_d;
    logic [ADDR_W-1:0]   end_addr_q, end_addr_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                done_q, done_d;
    logic [SAMPLE_W-1:0] word_q, word_d;
    logic [SAMPLE_W-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                dout_q, dout_d;
    logic [31:0]         rdata_q, rdata_d;

    logic                       lr_edge, lr_fall, sclk_fall;
    logic                       wr_en, rd_en, stereo, loop, busy;
    logic                       consume, reload, finish;
    logic [SAMPLE_W-1:0]        reload_word, atten_word;
    logic signed [SAMPLE_W-1:0] mem_s;
    logic                       unused_wdata;

    assign lr_edge   = lr_sync_q[2] ^ lr_sync_q[1];
    assign lr_fall   = lr_sync_q[2] & ~lr_sync_q[1];
    // An lrclk transition always coincides with an sclk falling edge on the wire.
    assign sclk_fall = (sclk_sync_q[2] & ~sclk_sync_q[1]) | lr_edge;

    assign wr_en  = AVL_WRITE & AVL_CS;
    assign rd_en  = AVL_READ & AVL_CS;
    assign loop   = ctrl_q[1];
    assign stereo = ctrl_q[2];
    assign busy   = (state_q != StIdle);

    assign mem_s      = mem_q;
    assign atten_word = mem_s >>> ctrl_q[6:4];

    assign unused_wdata = ^AVL_WRITEDATA;

    assign AVL_READDATA = rdata_q;
    assign mem_addr     = ptr_q;
    assign data_out     = dout_q;
    assign irq          = done_q & ctrl_q[3];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= StIdle;
            sclk_sync_q  <= '0;
            lr_sync_q    <= '0;
            ctrl_q       <= '0;
            start_addr_q <= '0;
            end_addr_q   <= '0;
            ptr_q        <= '0;
            done_q       <= 1'b0;
            word_q       <= '0;
            shreg_q      <= '0;
            cnt_q        <= '0;
            dout_q       <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            sclk_sync_q  <= {sclk_sync_q[1:0], sclk};
            lr_sync_q    <= {lr_sync_q[1:0], lrclk};
            ctrl_q       <= ctrl_d;
            start_addr_q <= start_addr_d;
            end_addr_q   <= end_addr_d;
            ptr_q        <= ptr_d;
            done_q       <= done_d;
            word_q       <= word_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ctrl_d       = ctrl_q;
        start_addr_d = start_addr_q;
        end_addr_d   = end_addr_q;
        ptr_d        = ptr_q;
        done_d       = done_q;
        word_d       = word_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        consume      = 1'b0;
        reload       = 1'b0;
        finish       = 1'b0;
        reload_word  = word_q;

        unique case (state_q)
            StIdle: dout_d = 1'b0;
            StArm: begin
                dout_d = 1'b0;
                if (lr_fall) begin
                    state_d = StPlay;
                    consume = 1'b1;
                end
            end
            StPlay: begin
                if (lr_edge) begin
                    if (lr_fall || stereo) consume = 1'b1;
                    else                   reload  = 1'b1;
                end
            end
            StDrain: begin
                if (lr_fall) begin
                    finish = 1'b1;
                end else if (lr_edge) begin
                    // Mono repeats the last word; a stereo right slot after the end is silent.
                    reload = 1'b1;
                    if (stereo) reload_word = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (consume) begin
            reload      = 1'b1;
            reload_word = atten_word;
            word_d      = atten_word;
            if (ptr_q >= end_addr_q) begin
                if (loop) begin
                    ptr_d = start_addr_q;
                end else begin
                    ptr_d   = ptr_q + ADDR_W'(1);
                    state_d = StDrain;
                end
            end else begin
                ptr_d = ptr_q + ADDR_W'(1);
            end
        end

        if (reload) begin
            shreg_d = reload_word;
            cnt_d   = '0;
            dout_d  = 1'b0;
        end else if ((state_q == StPlay || state_q == StDrain) && sclk_fall) begin
            if (cnt_q < CntW'(SAMPLE_W)) begin
                dout_d  = shreg_q[SAMPLE_W-1];
                shreg_d = {shreg_q[SAMPLE_W-2:0], 1'b0};
            end else begin
                dout_d = 1'b0;
            end
            if (cnt_q != CntW'(SLOT_W - 1)) cnt_d = cnt_q + CntW'(1);
        end

        if (finish) begin
            state_d   = StIdle;
            ctrl_d[0] = 1'b0;
        end

        if (wr_en) begin
            unique case (AVL_ADDR)
                2'd0: begin
                    ctrl_d = AVL_WRITEDATA[6:0];
                    if (AVL_WRITEDATA[0]) begin
                        state_d = StArm;
                        ptr_d   = start_addr_q;
                    end else begin
                        state_d = StIdle;
                    end
                end
                2'd1: start_addr_d = AVL_WRITEDATA[ADDR_W-1:0];
                2'd2: end_addr_d   = AVL_WRITEDATA[ADDR_W-1:0];
                2'd3: if (AVL_WRITEDATA[1]) done_d = 1'b0;
            endcase
        end

        // Setting done takes priority over a simultaneous software clear.
        if (finish) done_d = 1'b1;

        if (state_d == StIdle || state_d == StArm) dout_d = 1'b0;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = '0;
            unique case (AVL_ADDR)
                2'd0: rdata_d[6:0]        = ctrl_q;
                2'd1: rdata_d[ADDR_W-1:0] = start_addr_q;
                2'd2: rdata_d[ADDR_W-1:0] = end_addr_q;
                2'd3: begin
                    rdata_d[16 +: ADDR_W] = ptr_q;
                    rdata_d[1]            = done_q;
                    rdata_d[0]            = busy;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_sample_player.sv
// Directed bench for i2s_sample_player: a free-running I2S clock source, a sample
// memory model and a slot capture on sclk rising edges.
module tb_i2s_sample_player;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned SLOT_W   = 24;
    localparam int unsigned ADDR_W   = 15;

    logic                CLK = 1'b0;
    logic                RESET = 1'b1;
    logic                sclk = 1'b0;
    logic                lrclk = 1'b0;
    logic                AVL_READ = 1'b0;
    logic                AVL_WRITE = 1'b0;
    logic                AVL_CS = 1'b0;
    logic [1:0]          AVL_ADDR = 2'd0;
    logic [31:0]         AVL_WRITEDATA = 32'd0;
    logic [31:0]         AVL_READDATA;
    logic [ADDR_W-1:0]   mem_addr;
    logic [SAMPLE_W-1:0] mem_q;
    logic                data_out;
    logic                irq;

    logic [15:0] mem [0:63];
    int n_checks = 0;
    int n_fail   = 0;

    i2s_sample_player #(
        .SAMPLE_W(SAMPLE_W),
        .SLOT_W  (SLOT_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .sclk         (sclk),
        .lrclk        (lrclk),
        .AVL_READ     (AVL_READ),
        .AVL_WRITE    (AVL_WRITE),
        .AVL_CS       (AVL_CS),
        .AVL_ADDR     (AVL_ADDR),
        .AVL_WRITEDATA(AVL_WRITEDATA),
        .AVL_READDATA (AVL_READDATA),
        .mem_addr     (mem_addr),
        .mem_q        (mem_q),
        .data_out     (data_out),
        .irq          (irq)
    );

    always #5 CLK = ~CLK;

    // sclk period 160 ns (16 CLK); lrclk toggles on an sclk falling edge every SLOT_W bits.
    initial begin
        #3;
        forever begin
            for (int i = 0; i < SLOT_W; i++) begin
                #80 sclk = 1'b1;
                #80 sclk = 1'b0;
            end
            lrclk = ~lrclk;
        end
    end

    always @(posedge CLK) mem_q <= mem[mem_addr[5:0]];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at %0t, limit 2 ms", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic avl_wr(input logic [1:0] a, input logic [31:0] d);
        @(posedge CLK); #1;
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a; AVL_WRITEDATA = d;
        @(posedge CLK); #1;
        AVL_CS = 1'b0; AVL_WRITE = 1'b0;
    endtask

    task automatic avl_rd(input logic [1:0] a, output logic [31:0] d);
        @(posedge CLK); #1;
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
        @(posedge CLK); #1;
        AVL_CS = 1'b0; AVL_READ = 1'b0;
        d = AVL_READDATA;
    endtask

    // Called just after an lrclk edge; returns the SLOT_W bits of that slot.
    task automatic capture_slot(output logic [23:0] v);
        v = '0;
        for (int i = 0; i < SLOT_W; i++) begin
            @(posedge sclk);
            v = {v[22:0], data_out};
        end
    endtask

    task automatic wait_dout_high(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge CLK); #1;
            if (data_out === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #2 RESET = 1'b0;
        #1;
        n_checks++;
        if (data_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_data_out: got %b want 0", data_out);
        end
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_irq: got %b want 0", irq);
        end
        n_checks++;
        if (mem_addr !== '0) begin
            n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr);
        end
        n_checks++;
        if (AVL_READDATA !== 32'h0) begin
            n_fail++; $display("FAIL reset_readdata: got %h want 0", AVL_READDATA);
        end
        for (int a = 0; a < 4; a++) begin
            avl_rd(2'(a), rd);
            n_checks++;
            if (rd !== 32'h0) begin
                n_fail++; $display("FAIL reset_reg%0d: got %h want 00000000", a, rd);
            end
        end
    endtask

    task automatic test_mono();
        logic [31:0] rd;
        logic [23:0] v;
        @(posedge lrclk);
        avl_wr(2'd1, 32'd5);
        avl_wr(2'd2, 32'd5);
        avl_wr(2'd0, 32'h1);
        avl_rd(2'd3, rd);
        n_checks++;
        if (rd !== 32'h0005_0001) begin
            n_fail++; $display("FAIL mono_armed_status: got %h want 00050001", rd);
        end
        @(negedge lrclk);
        for (int s = 0; s < 2; s++) begin
            capture_slot(v);
            n_checks++;
            if (v !== 24'h400080) begin
                n_fail++; $display("FAIL mono_slot%0d: got %h want 400080", s, v);
            end
        end
        @(negedge lrclk);
        repeat (6) @(posedge CLK);
        avl_rd(2'd3, rd);
        n_checks++;
        if (rd !== 32'h0006_0002) begin
            n_fail++; $display("FAIL mono_done_status: got %h want 00060002", rd);
        end
        avl_rd(2'd0, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL mono_ctrl_cleared: got %h want 00000000", rd);
        end
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL mono_irq_masked: got %b want 0", irq);
        end
        avl_wr(2'd3, 32'h2);
        avl_rd(2'd3, rd);
        n_checks++;
        if (rd !== 32'h0006_0000) begin
            n_fail++; $display("FAIL mono_done_clear: got %h want 00060000", rd);
        end
    endtask

    task automatic test_stereo();
        logic [31:0] rd;
        logic [23:0] v;
        logic [23:0] exp_slot [4] = '{24'h088880, 24'h111100, 24'h199980, 24'h222200};
        @(posedge lrclk);
        avl_wr(2'd1, 32'd0);
        avl_wr(2'd2, 32'd3);
        avl_wr(2'd0, 32'hD);
        n_checks++;
        if (mem_addr !== 15'd0) begin
            n_fail++; $display("FAIL stereo_start_addr: got %0d want 0", mem_addr);
        end
        @(negedge lrclk);
        for (int k = 0; k < 4; k++) begin
            capture_slot(v);
            n_checks++;
            if (v !== exp_slot[k]) begin
                n_fail++; $display("FAIL stereo_slot%0d: got %h want %h", k, v, exp_slot[k]);
            end
            n_checks++;
            if (mem_addr !== 15'(k + 1)) begin
                n_fail++; $display("FAIL stereo_addr%0d: got %0d want %0d", k, mem_addr, k + 1);
            end
        end
        @(negedge lrclk);
        repeat (6) @(posedge CLK);
        avl_rd(2'd3, rd);
        n_checks++;
        if (rd !== 32'h0004_0002) begin
            n_fail++; $display("FAIL stereo_done_status: got %h want 00040002", rd);
        end
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL stereo_irq_set: got %b want 1", irq);
        end
        avl_wr(2'd3, 32'h2);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL stereo_irq_clear: got %b want 0", irq);
        end
    endtask

    task automatic test_atten();
        logic [31:0] rd;
        logic [23:0] v;
        @(posedge lrclk);
        avl_wr(2'd1, 32'd6);
        avl_wr(2'd2, 32'd7);
        avl_wr(2'd0, 32'h25);
        @(negedge lrclk);
        capture_slot(v);
        n_checks++;
        if (v !== 24'h700000) begin
            n_fail++; $display("FAIL atten_neg: got %h want 700000", v);
        end
        capture_slot(v);
        n_checks++;
        if (v !== 24'h0FFF80) begin
            n_fail++; $display("FAIL atten_pos: got %h want 0fff80", v);
        end
        @(negedge lrclk);
        repeat (6) @(posedge CLK);
        avl_rd(2'd3, rd);
        n_checks++;
        if (rd !== 32'h0008_0002) begin
            n_fail++; $display("FAIL atten_done_status: got %h want 00080002", rd);
        end
        avl_wr(2'd3, 32'h2);
    endtask

    task automatic test_loop_abort();
        logic [31:0] rd;
        logic [23:0] v;
        logic [23:0] want;
        bit ok;
        @(posedge lrclk);
        avl_wr(2'd1, 32'd2);
        avl_wr(2'd2, 32'd3);
        avl_wr(2'd0, 32'h3);
        @(negedge lrclk);
        for (int f = 0; f < 5; f++) begin
            want = (f % 2 == 0) ? 24'h199980 : 24'h222200;
            for (int s = 0; s < 2; s++) begin
                capture_slot(v);
                n_checks++;
                if (v !== want) begin
                    n_fail++; $display("FAIL loop_f%0d_s%0d: got %h want %h", f, s, v, want);
                end
            end
        end
        avl_rd(2'd3, rd);
        n_checks++;
        if (rd[1:0] !== 2'b01) begin
            n_fail++; $display("FAIL loop_busy: got %b want 01", rd[1:0]);
        end
        @(negedge lrclk);
        wait_dout_high(ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL loop_dout_active: got no high bit want one within 600 CLK");
        end
        avl_wr(2'd0, 32'h0);
        n_checks++;
        if (data_out !== 1'b0) begin
            n_fail++; $display("FAIL abort_dout: got %b want 0", data_out);
        end
        avl_rd(2'd3, rd);
        n_checks++;
        if (rd[1:0] !== 2'b00) begin
            n_fail++; $display("FAIL abort_status: got %b want 00", rd[1:0]);
        end
        @(lrclk);
        capture_slot(v);
        n_checks++;
        if (v !== 24'h0) begin
            n_fail++; $display("FAIL abort_silent: got %h want 000000", v);
        end
    endtask

    task automatic test_midframe_start();
        logic [23:0] v;
        int ones;
        @(posedge lrclk);
        repeat (100) @(posedge CLK);
        avl_wr(2'd1, 32'd8);
        avl_wr(2'd2, 32'd8);
        avl_wr(2'd0, 32'h1);
        ones = 0;
        for (int i = 0; i < 1000 && lrclk; i++) begin
            @(posedge CLK); #1;
            if (data_out !== 1'b0) ones++;
        end
        n_checks++;
        if (ones !== 0) begin
            n_fail++; $display("FAIL midframe_quiet: got %0d driven bits want 0", ones);
        end
        for (int s = 0; s < 2; s++) begin
            capture_slot(v);
            n_checks++;
            if (v !== 24'h2D2D00) begin
                n_fail++; $display("FAIL midframe_slot%0d: got %h want 2d2d00", s, v);
            end
        end
        @(negedge lrclk);
        repeat (6) @(posedge CLK);
        avl_wr(2'd3, 32'h2);
    endtask

    task automatic test_reset_during_play();
        logic [31:0] rd;
        logic [23:0] v0, v1;
        bit ok;
        @(posedge lrclk);
        avl_wr(2'd1, 32'd0);
        avl_wr(2'd2, 32'd3);
        avl_wr(2'd0, 32'hB);
        @(negedge lrclk);
        wait_dout_high(ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL rstplay_dout_active: got no high bit want one within 600 CLK");
        end
        avl_rd(2'd3, rd);
        n_checks++;
        if (rd[0] !== 1'b1) begin
            n_fail++; $display("FAIL rstplay_busy: got %b want 1", rd[0]);
        end
        #2 RESET = 1'b1;
        #1;
        n_checks++;
        if (data_out !== 1'b0) begin
            n_fail++; $display("FAIL rstplay_dout: got %b want 0", data_out);
        end
        n_checks++;
        if (mem_addr !== '0) begin
            n_fail++; $display("FAIL rstplay_mem_addr: got %h want 0", mem_addr);
        end
        n_checks++;
        if (AVL_READDATA !== 32'h0) begin
            n_fail++; $display("FAIL rstplay_readdata: got %h want 0", AVL_READDATA);
        end
        #40 RESET = 1'b0;
        for (int a = 0; a < 4; a++) begin
            avl_rd(2'(a), rd);
            n_checks++;
            if (rd !== 32'h0) begin
                n_fail++; $display("FAIL rstplay_reg%0d: got %h want 00000000", a, rd);
            end
        end
        @(lrclk);
        capture_slot(v0);
        capture_slot(v1);
        n_checks++;
        if ((v0 | v1) !== 24'h0) begin
            n_fail++; $display("FAIL rstplay_silent: got %h/%h want 000000", v0, v1);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0;
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        mem[2] = 16'h3333;
        mem[3] = 16'h4444;
        mem[5] = 16'h8001;
        mem[6] = 16'h8000;
        mem[7] = 16'h7FFF;
        mem[8] = 16'h5A5A;

        test_reset();
        test_mono();
        test_stereo();
        test_atten();
        test_loop_abort();
        test_midframe_start();
        test_reset_during_play();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_sample_player.md
Name: i2s_sample_player

Overview:
- Parametrised I2S transmitter that plays a PCM clip from an external synchronous sample ROM/RAM.
- Software controls it over an Avalon-MM slave through start/end address registers, loop, mono/stereo and attenuation controls, plus busy/done status.
- Supersedes the fixed-length, fixed-width explosion player.
- Sits between the Nios Avalon fabric, a sample memory and the external codec (sclk/lrclk supplied by codec or clock generator).

Parameters:
- SAMPLE_W, 16, bits per sample (signed two's complement), 8..24.
- SLOT_W, 24, sclk periods per lrclk half-frame; must be ≥ SAMPLE_W+1.
- ADDR_W, 15, sample memory address width.

Ports:
- CLK  in  1  system clock; must be ≥ 8× sclk frequency.
- RESET  in  1  asynchronous, active-high reset.
- sclk  in  1  I2S bit clock, asynchronous to CLK.
- lrclk  in  1  I2S word select; low = left, high = right.
- AVL_READ  in  1  Avalon read.
- AVL_WRITE  in  1  Avalon write.
- AVL_CS  in  1  chip select.
- AVL_ADDR  in  2  word address.
- AVL_WRITEDATA  in  32  write data.
- AVL_READDATA  out  32  read data, registered.
- mem_addr  out  ADDR_W  sample memory address.
- mem_q  in  SAMPLE_W  sample memory data, 1-cycle read latency.
- data_out  out  1  I2S serial data.
- irq  out  1  level interrupt = done & irq_en.

Behaviour:
- Reset values: all registers 0; data_out 0; AVL_READDATA 0; mem_addr 0; irq 0.
- Register map (byte enables ignored):
  - 0 CTRL: [0] start, [1] loop, [2] stereo, [3] irq_en, [6:4] atten.
  - 1 START_ADDR: [ADDR_W-1:0].
  - 2 END_ADDR: [ADDR_W-1:0].
  - 3 STATUS: [0] busy (RO), [1] done (write 1 to clear), [16+ADDR_W-1:16] current address (RO).
- Reads: AVL_READDATA is valid the cycle after AVL_READ&AVL_CS; unused bits read 0.
- Input conditioning: sclk and lrclk pass through 2-flop synchronisers; edges are detected on the synchronised values. Any lrclk edge is also treated as an sclk falling edge.
- State machine IDLE → ARM → PLAY → DRAIN → IDLE.
  - IDLE: data_out 0, busy 0. A write with CTRL[0] 0→1 (or start=1 written while already 1) loads ptr ← START_ADDR and moves to ARM.
  - ARM: busy 1. Waits for lrclk falling edge (frame alignment); then moves to PLAY, consuming the left sample.
  - PLAY, at each lrclk edge:
    - Latch the shift word = (mem_q >>> atten), arithmetic shift.
    - Drive data_out 0 for the delay bit.
    - On each following sclk falling edge, shift out SAMPLE_W bits MSB first, then drive 0 for the rest of the slot.
  - Pointer advance:
    - Mono: at lrclk falling edge only; the right slot repeats the left word.
    - Stereo: at every lrclk edge (left = even, right = odd consumed sample).
    - The advance happens in the same cycle as the latch. mem_addr = ptr at all times, so mem_q is settled long before the next edge.
  - Termination (evaluated at each advance): if ptr ≥ END_ADDR, then loop=1 → ptr ← START_ADDR; loop=0 → go to DRAIN. END_ADDR < START_ADDR therefore plays exactly one sample.
  - DRAIN: finishes the current frame. At the next lrclk falling edge go to IDLE, set done, clear CTRL[0].
- Writing CTRL[0]=0 while busy aborts: the next CLK goes to IDLE, data_out 0, done not set.
- Writing start=1 while busy restarts: ptr ← START_ADDR, go to ARM.
- START_ADDR/END_ADDR writes during playback take effect at the next termination check or wrap.
- Simultaneous done-clear write and done-set: set wins.
- loop and atten may change mid-play; atten applies from the next latched sample.

Test Plan:
- Mono, SAMPLE_W=16: mem holds 0x8001 at addr 5; START=5, END=5, start → left and right slots each show bit 0, then 1000000000000001, then 7 zeros. done=1 and busy=0 at the following lrclk falling edge; CTRL reads 0.
- Stereo: START=0, END=3, samples 0x1111/0x2222/0x3333/0x4444 → frames (L,R) = (1111,2222),(3333,4444); mem_addr 0→1→2→3→4, then IDLE.
- Loop: START=2, END=3, loop=1, mono, run 5 frames → consumed addresses 2,3,2,3,2; busy remains 1; clearing start → data_out 0 within 1 CLK, done stays 0.
- Attenuation: atten=2, sample 0x8000 → serial word 0xE000; sample 0x7FFF → 0x1FFF.
- Start mid-frame (lrclk high): no bits are driven until the next lrclk falling edge, then the left slot plays START's sample.
- Assert RESET during PLAY mid-word → data_out 0, busy 0, all registers 0 immediately. After release, no output until software writes start.
